// File: rtl/seq_mul32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_mul32                                                        |
// | Brief   : Shift-add multiplier, one multiplier bit per clock, toggle       |
// |           handshake (pending while run_in != run_out). Optional macro      |
// |           MUL_OVF_EN adds the ovf output (high-half significance flag).    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seq_mul32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mul,
  input  logic               run_in,
  output logic               run_out,
`ifdef MUL_OVF_EN
  output logic               ovf,
`endif
  output logic [2*WIDTH-1:0] p
);

  localparam int               c_CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]     r_mb;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_run_out;
  logic [2*WIDTH-1:0]   r_p;

  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_res;

  // Negating the most negative value yields the same bit pattern, which is
  // exactly its magnitude when read as unsigned.
  assign w_a_mag = (signed_mul & a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag = (signed_mul & b[WIDTH-1]) ? (~b + 1'b1) : b;
  assign w_res   = r_neg ? ({(2*WIDTH){1'b0}} - r_acc) : r_acc;

`ifdef MUL_OVF_EN
  logic r_sgn;
  logic r_ovf;
  logic w_ovf;

  assign w_ovf = r_sgn ? (w_res[2*WIDTH-1:WIDTH] != {WIDTH{w_res[WIDTH-1]}})
                       : (|w_res[2*WIDTH-1:WIDTH]);
  assign ovf   = r_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sgn <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (r_state == c_IDLE && run_in != r_run_out) begin
        r_sgn <= signed_mul;
      end
      if (r_state == c_DONE) begin
        r_ovf <= w_ovf;
      end
    end
  end
`endif

  // The multiplicand is kept pre-shifted so each step adds it directly.
  // BUSY spends one extra edge after the last bit so completion lands
  // WIDTH+2 edges after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_run_out <= 1'b0;
      r_p       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (run_in != r_run_out) begin
            r_ma    <= {{WIDTH{1'b0}}, w_a_mag};
            r_mb    <= w_b_mag;
            r_neg   <= signed_mul & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= c_BUSY;
          end
        end
        c_BUSY: begin
          if (r_cnt == c_CNT_LAST) begin
            r_state <= c_DONE;
          end else begin
            if (r_mb[0]) begin
              r_acc <= r_acc + r_ma;
            end
            r_ma  <= r_ma << 1;
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_DONE: begin
          r_p       <= w_res;
          r_run_out <= ~r_run_out;
          r_state   <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign run_out = r_run_out;
  assign p       = r_p;

endmodule
`default_nettype wire

// File: tb/tb_seq_mul32.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seq_mul32                                                     |
// | Brief   : Directed vector table plus back-to-back and abort sequences.     |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seq_mul32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_mul;
  logic        run_in;
  logic        run_out;
  logic [63:0] p;
`ifdef MUL_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  seq_mul32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .signed_mul (signed_mul),
    .run_in     (run_in),
    .run_out    (run_out),
`ifdef MUL_OVF_EN
    .ovf        (ovf),
`endif
    .p          (p)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    logic [63:0] exp_p;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for the completion toggle.
  // lat counts edges after the capture edge; -1 means the bound expired.
  task automatic run_mul(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                         output int lat, output bit stable, output int done_cyc);
    logic        ro0;
    logic [63:0] p0;
    int          n;
    @(negedge clk);
    a = ia;
    b = ib;
    signed_mul = is;
    ro0 = run_out;
    p0 = p;
    run_in = ~run_in;
    stable = 1'b1;
    lat = -1;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (run_out !== ro0) break;
      if (p !== p0) stable = 1'b0;
    end
    if (n < 100) lat = n - 1;
    done_cyc = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  stable;
    int  c1;
    int  c2;
    bit  toggled;

    vecs[0]  = '{32'd7,        32'd6,        1'b0, 64'h0000_0000_0000_002A, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1};
    vecs[2]  = '{32'hFFFFFFFD, 32'd5,        1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h4000_0000_0000_0000, 1'b1};
    vecs[4]  = '{32'h80000000, 32'd2,        1'b0, 64'h0000_0001_0000_0000, 1'b1};
    vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b0};
    vecs[6]  = '{32'd0,        32'h12345678, 1'b0, 64'h0000_0000_0000_0000, 1'b0};
    vecs[7]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0};
    vecs[8]  = '{32'h80000000, 32'd1,        1'b1, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[9]  = '{32'hFFFFFFFD, 32'd5,        1'b0, 64'h0000_0004_FFFF_FFF1, 1'b1};
    vecs[10] = '{32'h12345678, 32'hFFFFFFFE, 1'b1, 64'hFFFF_FFFF_DB97_5310, 1'b0};

    reset = 1'b1;
    run_in = 1'b0;
    a = '0;
    b = '0;
    signed_mul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_run_out", {63'b0, run_out}, 64'd0);
    check("reset_p", p, 64'd0);
`ifdef MUL_OVF_EN
    check("reset_ovf", {63'b0, ovf}, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_mul(vecs[i].a, vecs[i].b, vecs[i].sgn, lat, stable, c1);
      check($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      check($sformatf("vec%0d_p_hold", i), {63'b0, stable}, 64'd1);
`ifdef MUL_OVF_EN
      check($sformatf("vec%0d_ovf", i), {63'b0, ovf}, {63'b0, vecs[i].exp_ovf});
`endif
    end

    // Back-to-back: second request toggled in the cycle right after completion.
    run_mul(32'd3, 32'd4, 1'b0, lat, stable, c1);
    check("b2b_first_p", p, 64'hC);
    run_mul(32'h10000, 32'h10000, 1'b0, lat, stable, c2);
    check("b2b_second_p", p, 64'h0000_0001_0000_0000);
    check("b2b_gap", 64'(c2 - c1), 64'd35);
    check("b2b_p_hold", {63'b0, stable}, 64'd1);

    // Abort: reset 10 cycles into a multiply, requester clears run_in.
    @(negedge clk);
    a = 32'd5;
    b = 32'd7;
    signed_mul = 1'b0;
    run_in = ~run_in;
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_in = 1'b0;
    @(posedge clk);
    #1;
    check("abort_run_out", {63'b0, run_out}, 64'd0);
    check("abort_p", p, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    toggled = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (run_out !== 1'b0) toggled = 1'b1;
    end
    check("abort_no_toggle", {63'b0, toggled}, 64'd0);
    run_mul(32'd2, 32'd3, 1'b0, lat, stable, c1);
    check("after_abort_p", p, 64'd6);
    check("after_abort_latency", 64'(lat), 64'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_mul32.md
Name: seq_mul32

Overview:
Sequential shift-add multiplier, the inverse companion of the core's iterative 64/32 divider. Used by the CPU MUL/IMUL path.
- Multiplies two WIDTH-bit operands into a 2*WIDTH-bit product, signed or unsigned.
- Retires one multiplier bit per clock.
- Uses the same toggle handshake as the divider: a request is pending while run_in != run_out.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits; iteration counter is $clog2(WIDTH)+1 bits.

Ports:
clk  input  1  rising-edge clock, single clock domain
reset  input  1  synchronous, active-high reset
a  input  WIDTH  multiplicand; must be stable from the run_in toggle until the capture edge
b  input  WIDTH  multiplier; same stability rule as a
signed_mul  input  1  1 = two's-complement operands, 0 = unsigned; sampled at the capture edge
run_in  input  1  request toggle from the requester
run_out  output  1  completion toggle; equals run_in when idle or done
p  output  2*WIDTH  product; p[WIDTH-1:0] is the low half, p[2*WIDTH-1:WIDTH] is the high half

Behaviour:
Reset:
- Synchronous; wins over everything.
- Outputs: run_out=0, p=0, state=IDLE, counter=0, internal accumulator=0.
- Reset mid-operation aborts the multiply with no completion toggle. The requester must also return run_in to 0.

States:
- IDLE: when run_in != run_out at a rising edge (the capture edge):
  - latch magnitudes ma = (signed_mul & a[W-1]) ? -a : a and mb likewise for b;
  - latch neg = signed_mul & (a[W-1]^b[W-1]);
  - clear the 2W-bit accumulator acc;
  - set counter=0; go to BUSY.
- BUSY: each edge:
  - if mb[0], acc <= acc + (ma << counter);
  - mb <= mb >> 1; counter <= counter+1;
  - after the edge where counter reaches WIDTH (i.e. WIDTH BUSY edges), go to DONE.
- DONE: one edge:
  - p <= neg ? (0 - acc) : acc, in 2W-bit arithmetic;
  - run_out <= ~run_out; go to IDLE.

Timing and handshake:
- Latency: run_out toggles exactly WIDTH+2 edges after the capture edge, i.e. 34 for WIDTH=32.
- p holds its previous value during BUSY and changes only on the DONE edge. This differs from the divider, whose outputs track the intermediate state.
- Toggles on run_in while busy are ignored; the requester must not toggle again before run_out matches.
- Back-to-back: if run_in toggles in the cycle after completion, the next IDLE edge captures the new request. There are no dead cycles beyond IDLE.

Arithmetic:
- Magnitude of -2^(W-1) is 2^(W-1), represented as unsigned W bits, so no overflow occurs.
- acc never exceeds (2^W-1)^2 < 2^(2W).
- Signed results are correct two's complement over 2W bits.
- Zero operands still take full latency.
- signed_mul=0 treats all bits as magnitude.

Optional Feature:
MUL_OVF_EN:
- Defined: adds output port ovf (1 bit), reset 0, updated on the DONE edge together with p. It drives x86 CF/OF.
  - Unsigned: ovf = |p_high.
  - Signed: ovf = (p_high != {WIDTH{p[WIDTH-1]}}).
- Undefined: port absent. Timing and p are identical in both builds.

Test Plan:
- Unsigned a=7, b=6 -> p=0x000000000000002A; run_out toggles 34 edges after the capture edge; ovf=0.
- Unsigned a=b=0xFFFFFFFF -> p=0xFFFFFFFE00000001; ovf=1.
- Signed a=0xFFFFFFFD (-3), b=5 -> p=0xFFFFFFFFFFFFFFF1; ovf=0.
- Signed a=b=0x80000000 -> p=0x4000000000000000; ovf=1.
- Back-to-back: 3*4, then toggle run_in the cycle after completion with 0x10000*0x10000 -> p=0xC, then p=0x0000000100000000. The second run_out toggle comes 35 edges after the first, and p stays 0xC throughout the second BUSY.
- Reset asserted 10 cycles into a multiply (with run_in also cleared) -> run_out=0, p=0 on the next edge; no toggle follows; a subsequent 2*3 request yields p=6.
